// File: rtl/scfifo_wc.sv
// Single-clock FIFO with width conversion between write and read ports.
// Storage is lane-granular (lane = min width), so up- and down-sizing share one datapath.
module scfifo_wc #(
  parameter int DEPTH     = 16,
  parameter int I_WIDTH   = 32,
  parameter int O_WIDTH   = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int AF_LEVEL  = DEPTH * ((I_WIDTH > O_WIDTH ? I_WIDTH : O_WIDTH) /
                                     (I_WIDTH < O_WIDTH ? I_WIDTH : O_WIDTH))
                          - ((I_WIDTH > O_WIDTH ? I_WIDTH : O_WIDTH) /
                             (I_WIDTH < O_WIDTH ? I_WIDTH : O_WIDTH)),
  parameter int AE_LEVEL  = (I_WIDTH > O_WIDTH ? I_WIDTH : O_WIDTH) /
                            (I_WIDTH < O_WIDTH ? I_WIDTH : O_WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_fifo_clr,
  input  logic               i_wr_en,
  input  logic [I_WIDTH-1:0] i_din,
  input  logic               i_rd_en,
  output logic [O_WIDTH-1:0] o_dout,
  output logic               o_dout_valid,
  output logic               o_full,
  output logic               o_empty,
  output logic               o_almost_full,
  output logic               o_almost_empty,
  output logic [$clog2(DEPTH * ((I_WIDTH > O_WIDTH ? I_WIDTH : O_WIDTH) /
                                (I_WIDTH < O_WIDTH ? I_WIDTH : O_WIDTH))):0] o_level,
  output logic               o_overflow,
  output logic               o_underflow
);

  localparam int WMAX = (I_WIDTH > O_WIDTH) ? I_WIDTH : O_WIDTH;
  localparam int G    = (I_WIDTH < O_WIDTH) ? I_WIDTH : O_WIDTH;
  localparam int R    = WMAX / G;
  localparam int L    = DEPTH * R;
  localparam int AW   = $clog2(L);
  localparam int LW   = AW + 1;
  localparam int IL   = I_WIDTH / G;
  localparam int OL   = O_WIDTH / G;

  localparam logic [LW-1:0] L_CAP = LW'(L);
  localparam logic [LW-1:0] IL_N  = LW'(IL);
  localparam logic [LW-1:0] OL_N  = LW'(OL);
  localparam logic [LW-1:0] AF_N  = LW'(AF_LEVEL);
  localparam logic [LW-1:0] AE_N  = LW'(AE_LEVEL);

  logic [G-1:0]       r_mem [L];
  logic [LW-1:0]      r_wptr;
  logic [LW-1:0]      r_rptr;
  logic [LW-1:0]      w_level;
  logic [LW-1:0]      w_free;
  logic               w_wr_ok;
  logic               w_rd_ok;
  logic [O_WIDTH-1:0] w_rd_word;

  // Pointers carry a wrap bit, so their difference is the occupancy directly.
  assign w_level = r_wptr - r_rptr;
  assign w_free  = L_CAP - w_level;
  assign w_wr_ok = i_wr_en && (w_free >= IL_N) && !i_fifo_clr;
  assign w_rd_ok = i_rd_en && (w_level >= OL_N) && !i_fifo_clr;

  assign o_level        = w_level;
  assign o_full         = (w_free < IL_N);
  assign o_empty        = (w_level < OL_N);
  assign o_almost_full  = (w_level >= AF_N);
  assign o_almost_empty = (w_level <= AE_N);

  always_ff @(posedge clk) begin
    if (w_wr_ok && rst_n) begin
      for (int k = 0; k < IL; k++) begin
        if (MSB_FIRST)
          r_mem[r_wptr[AW-1:0] + AW'(k)] <= i_din[I_WIDTH-1-k*G -: G];
        else
          r_mem[r_wptr[AW-1:0] + AW'(k)] <= i_din[k*G +: G];
      end
    end
  end

  // Read lanes are occupied and write lanes are free, so same-cycle access never overlaps.
  always_comb begin
    w_rd_word = '0;
    for (int k = 0; k < OL; k++) begin
      if (MSB_FIRST)
        w_rd_word[O_WIDTH-1-k*G -: G] = r_mem[r_rptr[AW-1:0] + AW'(k)];
      else
        w_rd_word[k*G +: G] = r_mem[r_rptr[AW-1:0] + AW'(k)];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      o_dout       <= '0;
      o_dout_valid <= 1'b0;
      o_overflow   <= 1'b0;
      o_underflow  <= 1'b0;
    end else if (i_fifo_clr) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      o_dout_valid <= 1'b0;
      o_overflow   <= 1'b0;
      o_underflow  <= 1'b0;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + IL_N;
      if (w_rd_ok) begin
        r_rptr <= r_rptr + OL_N;
        o_dout <= w_rd_word;
      end
      o_dout_valid <= w_rd_ok;
      o_overflow   <= i_wr_en && !w_wr_ok;
      o_underflow  <= i_rd_en && !w_rd_ok;
    end
  end

endmodule

// File: tb/tb_scfifo_wc.sv
// Directed bench for scfifo_wc: downsize, upsize and equal-width instances share clock and reset.
module tb_scfifo_wc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  // downsize 32 -> 8, MSB first, DEPTH 16 (64 lanes)
  logic        d_clr = 0, d_wr = 0, d_rd = 0;
  logic [31:0] d_din = '0;
  logic [7:0]  d_dout;
  logic        d_dv, d_full, d_empty, d_af, d_ae, d_ovf, d_unf;
  logic [6:0]  d_level;

  // upsize 8 -> 32, LSB first, DEPTH 16 (64 lanes)
  logic        u_clr = 0, u_wr = 0, u_rd = 0;
  logic [7:0]  u_din = '0;
  logic [31:0] u_dout;
  logic        u_dv, u_full, u_empty, u_af, u_ae, u_ovf, u_unf;
  logic [6:0]  u_level;

  // equal width 32/32, DEPTH 4
  logic        e_clr = 0, e_wr = 0, e_rd = 0;
  logic [31:0] e_din = '0;
  logic [31:0] e_dout;
  logic        e_dv, e_full, e_empty, e_af, e_ae, e_ovf, e_unf;
  logic [2:0]  e_level;

  scfifo_wc #(.DEPTH(16), .I_WIDTH(32), .O_WIDTH(8), .MSB_FIRST(1'b1)) u_dn (
    .clk(clk), .rst_n(rst_n), .i_fifo_clr(d_clr), .i_wr_en(d_wr), .i_din(d_din),
    .i_rd_en(d_rd), .o_dout(d_dout), .o_dout_valid(d_dv), .o_full(d_full),
    .o_empty(d_empty), .o_almost_full(d_af), .o_almost_empty(d_ae),
    .o_level(d_level), .o_overflow(d_ovf), .o_underflow(d_unf));

  scfifo_wc #(.DEPTH(16), .I_WIDTH(8), .O_WIDTH(32), .MSB_FIRST(1'b0)) u_up (
    .clk(clk), .rst_n(rst_n), .i_fifo_clr(u_clr), .i_wr_en(u_wr), .i_din(u_din),
    .i_rd_en(u_rd), .o_dout(u_dout), .o_dout_valid(u_dv), .o_full(u_full),
    .o_empty(u_empty), .o_almost_full(u_af), .o_almost_empty(u_ae),
    .o_level(u_level), .o_overflow(u_ovf), .o_underflow(u_unf));

  scfifo_wc #(.DEPTH(4), .I_WIDTH(32), .O_WIDTH(32), .MSB_FIRST(1'b1)) u_eq (
    .clk(clk), .rst_n(rst_n), .i_fifo_clr(e_clr), .i_wr_en(e_wr), .i_din(e_din),
    .i_rd_en(e_rd), .o_dout(e_dout), .o_dout_valid(e_dv), .o_full(e_full),
    .o_empty(e_empty), .o_almost_full(e_af), .o_almost_empty(e_ae),
    .o_level(e_level), .o_overflow(e_ovf), .o_underflow(e_unf));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    // {level, empty, full, almost_empty, dout_valid, overflow, underflow, dout}
    n_chk++; if ({d_level, d_empty, d_full, d_ae, d_dv, d_ovf, d_unf, d_dout} !== {7'd0, 6'b101000, 8'h00})
      $display("FAIL reset_dn got %h exp %h", {d_level, d_empty, d_full, d_ae, d_dv, d_ovf, d_unf, d_dout}, {7'd0, 6'b101000, 8'h00}); else n_pass++;
    n_chk++; if ({u_level, u_empty, u_full, u_ae, u_dv, u_ovf, u_unf, u_dout} !== {7'd0, 6'b101000, 32'h0})
      $display("FAIL reset_up got %h exp %h", {u_level, u_empty, u_full, u_ae, u_dv, u_ovf, u_unf, u_dout}, {7'd0, 6'b101000, 32'h0}); else n_pass++;
    n_chk++; if ({e_level, e_empty, e_full, e_ae, e_dv, e_ovf, e_unf, e_dout} !== {3'd0, 6'b101000, 32'h0})
      $display("FAIL reset_eq got %h exp %h", {e_level, e_empty, e_full, e_ae, e_dv, e_ovf, e_unf, e_dout}, {3'd0, 6'b101000, 32'h0}); else n_pass++;
  endtask

  task automatic test_downsize();
    logic [7:0] exp_b [4];
    exp_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    d_din = 32'hAABBCCDD;
    d_wr  = 1'b1;
    tick();
    d_wr = 1'b0;
    n_chk++; if (d_level !== 7'd4) $display("FAIL dn_level_after_write got %0d exp 4", d_level); else n_pass++;
    n_chk++; if ({d_empty, d_ae} !== 2'b01) $display("FAIL dn_empty_ae got %b exp 01", {d_empty, d_ae}); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      d_rd = 1'b1;
      tick();
      n_chk++; if (d_dout !== exp_b[i] || d_dv !== 1'b1)
        $display("FAIL dn_read%0d got %h/%b exp %h/1", i, d_dout, d_dv, exp_b[i]); else n_pass++;
      n_chk++; if (d_level !== 7'(3 - i)) $display("FAIL dn_level%0d got %0d exp %0d", i, d_level, 3 - i); else n_pass++;
    end
    d_rd = 1'b0;
    tick();
    n_chk++; if ({d_empty, d_dv, d_dout} !== {2'b10, 8'hDD})
      $display("FAIL dn_drained got %h exp %h", {d_empty, d_dv, d_dout}, {2'b10, 8'hDD}); else n_pass++;
  endtask

  task automatic test_upsize();
    logic [7:0] bytes_in [3];
    bytes_in = '{8'h11, 8'h22, 8'h33};
    u_wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      u_din = bytes_in[i];
      tick();
    end
    u_wr = 1'b0;
    n_chk++; if ({u_level, u_empty} !== {7'd3, 1'b1}) $display("FAIL up_partial got %0d/%b exp 3/1", u_level, u_empty); else n_pass++;
    u_din = 8'h44;
    u_wr  = 1'b1;
    tick();
    u_wr = 1'b0;
    n_chk++; if ({u_level, u_empty} !== {7'd4, 1'b0}) $display("FAIL up_whole got %0d/%b exp 4/0", u_level, u_empty); else n_pass++;
    u_rd = 1'b1;
    tick();
    u_rd = 1'b0;
    n_chk++; if (u_dout !== 32'h44332211 || u_dv !== 1'b1)
      $display("FAIL up_read got %h/%b exp 44332211/1", u_dout, u_dv); else n_pass++;
    n_chk++; if ({u_level, u_empty} !== {7'd0, 1'b1}) $display("FAIL up_after_read got %0d/%b exp 0/1", u_level, u_empty); else n_pass++;
  endtask

  task automatic test_full();
    e_wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      e_din = 32'h1000_0000 + i;
      tick();
      if (i == 2) begin
        n_chk++; if (e_full !== 1'b0) $display("FAIL eq_not_full_at3 got %b exp 0", e_full); else n_pass++;
      end
      if (i == 3) begin
        n_chk++; if ({e_full, e_af, e_ovf, e_level} !== {3'b110, 3'd4})
          $display("FAIL eq_full_at4 got %b exp 1104", {e_full, e_af, e_ovf, e_level}); else n_pass++;
      end
    end
    e_wr = 1'b0;
    n_chk++; if ({e_ovf, e_level} !== {1'b1, 3'd4}) $display("FAIL eq_overflow got %b/%0d exp 1/4", e_ovf, e_level); else n_pass++;
    tick();
    n_chk++; if (e_ovf !== 1'b0) $display("FAIL eq_overflow_pulse got %b exp 0", e_ovf); else n_pass++;
    e_rd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++; if (e_dout !== 32'h1000_0000 + i || e_dv !== 1'b1)
        $display("FAIL eq_read%0d got %h/%b exp %h/1", i, e_dout, e_dv, 32'h1000_0000 + i); else n_pass++;
    end
    e_rd = 1'b0;
    tick();
    n_chk++; if ({e_empty, e_level} !== {1'b1, 3'd0}) $display("FAIL eq_drained got %b/%0d exp 1/0", e_empty, e_level); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] q[$];
    logic [31:0] exp_d;
    logic        wr_acc, rd_acc;
    int          n;
    exp_d = e_dout;
    e_wr  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e_din = 32'h2000_0000 + i;
      q.push_back(e_din);
      tick();
    end
    e_rd = 1'b1;
    for (int c = 0; c < 8; c++) begin
      e_din  = 32'h3000_0000 + c;
      wr_acc = (4 - q.size()) >= 1;
      rd_acc = q.size() >= 1;
      if (rd_acc) exp_d = q.pop_front();
      if (wr_acc) q.push_back(e_din);
      tick();
      n_chk++; if ({e_dout, e_dv, e_ovf, e_level} !== {exp_d, rd_acc, !wr_acc, 3'(q.size())})
        $display("FAIL b2b_cycle%0d got %h/%b/%b/%0d exp %h/%b/%b/%0d", c, e_dout, e_dv, e_ovf, e_level,
                 exp_d, rd_acc, !wr_acc, q.size()); else n_pass++;
    end
    e_wr = 1'b0;
    n = q.size();
    for (int i = 0; i < n; i++) begin
      exp_d = q.pop_front();
      tick();
      n_chk++; if (e_dout !== exp_d || e_dv !== 1'b1)
        $display("FAIL b2b_drain%0d got %h/%b exp %h/1", i, e_dout, e_dv, exp_d); else n_pass++;
    end
    e_rd = 1'b0;
    tick();
  endtask

  task automatic test_underflow();
    d_rd = 1'b1;
    tick();
    d_rd = 1'b0;
    n_chk++; if ({d_unf, d_dv, d_level, d_dout} !== {2'b10, 7'd0, 8'hDD})
      $display("FAIL underflow got %h exp %h", {d_unf, d_dv, d_level, d_dout}, {2'b10, 7'd0, 8'hDD}); else n_pass++;
    tick();
    n_chk++; if (d_unf !== 1'b0) $display("FAIL underflow_pulse got %b exp 0", d_unf); else n_pass++;
  endtask

  task automatic test_clear_reset();
    d_wr  = 1'b1;
    d_din = 32'h01020304;
    tick();
    d_din = 32'h05060708;
    tick();
    d_din = 32'h090A0B0C;
    d_rd  = 1'b1;
    tick();
    n_chk++; if ({d_level, d_dout} !== {7'd11, 8'h01}) $display("FAIL simul_rw got %0d/%h exp 11/01", d_level, d_dout); else n_pass++;
    d_wr = 1'b0;
    tick();
    d_rd = 1'b0;
    n_chk++; if ({d_level, d_dout} !== {7'd10, 8'h02}) $display("FAIL level10 got %0d/%h exp 10/02", d_level, d_dout); else n_pass++;
    d_clr = 1'b1;
    d_wr  = 1'b1;
    d_din = 32'hFFFF_FFFF;
    tick();
    d_clr = 1'b0;
    d_wr  = 1'b0;
    n_chk++; if ({d_level, d_empty, d_dv} !== {7'd0, 2'b10}) $display("FAIL clear got %0d/%b/%b exp 0/1/0", d_level, d_empty, d_dv); else n_pass++;
    d_wr  = 1'b1;
    d_din = 32'hDEADBEEF;
    tick();
    d_rd = 1'b1;
    tick();
    n_chk++; if ({d_level, d_dout, d_dv} !== {7'd7, 8'hDE, 1'b1}) $display("FAIL burst got %0d/%h/%b exp 7/de/1", d_level, d_dout, d_dv); else n_pass++;
    rst_n = 1'b0;
    tick();
    n_chk++; if ({d_level, d_empty, d_full, d_ae, d_dv, d_ovf, d_unf, d_dout} !== {7'd0, 6'b101000, 8'h00})
      $display("FAIL midreset got %h exp %h", {d_level, d_empty, d_full, d_ae, d_dv, d_ovf, d_unf, d_dout}, {7'd0, 6'b101000, 8'h00}); else n_pass++;
    rst_n = 1'b1;
    d_wr  = 1'b0;
    d_rd  = 1'b0;
    tick();
    n_chk++; if ({d_level, d_empty} !== {7'd0, 1'b1}) $display("FAIL postreset got %0d/%b exp 0/1", d_level, d_empty); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_downsize();
    test_upsize();
    test_full();
    test_back_to_back();
    test_underflow();
    test_clear_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule

// File: doc/scfifo_wc.md
SCFIFO_WC -- requirements
Module: scfifo_wc

Interface
REQ-001 Parameter DEPTH, 16, FIFO capacity in words of width max(I_WIDTH,O_WIDTH); power of two, >=2.
REQ-002 Parameter I_WIDTH, 32, write word width.
REQ-003 Parameter O_WIDTH, 8, read word width; max/min of I_WIDTH and O_WIDTH SHALL be a power of two (1..32).
REQ-004 Parameter MSB_FIRST, 1, 1: first lane in time occupies the most significant bits of the wider word; 0: least significant bits.
REQ-005 Parameter AF_LEVEL, DEPTH*R-R, almost_full threshold in lanes (R = ratio, lane G = min width).
REQ-006 Parameter AE_LEVEL, R, almost_empty threshold in lanes.
REQ-007 clk  in  1  clock; all state SHALL update on its rising edge.
REQ-008 rst_n  in  1  reset, synchronous, active-low.
REQ-009 fifo_clr  in  1  synchronous clear of pointers and level, data contents don't-care.
REQ-010 wr_en  in  1  write request.
REQ-011 din  in  I_WIDTH  write data.
REQ-012 rd_en  in  1  read request.
REQ-013 dout  out  O_WIDTH  read data, registered.
REQ-014 dout_valid  out  1  one-cycle pulse qualifying dout.
REQ-015 full / empty  out  1 each  status, combinational from current level.
REQ-016 almost_full / almost_empty  out  1 each  threshold status.
REQ-017 level  out  clog2(DEPTH*R)+1  occupancy in lanes.
REQ-018 overflow / underflow  out  1 each  registered one-cycle error pulses.

Function
REQ-019 Storage SHALL be DEPTH*R lanes of G bits; capacity L = DEPTH*R lanes; pointers are lane-granular with one extra wrap bit.
REQ-020 Write accepted when wr_en and free lanes (L-level) >= I_WIDTH/G; accepted word SHALL occupy I_WIDTH/G consecutive lanes in MSB_FIRST order.
REQ-021 Read accepted when rd_en and level >= O_WIDTH/G; it SHALL consume O_WIDTH/G lanes, assembled in MSB_FIRST order.
REQ-022 full SHALL equal (L-level < I_WIDTH/G); empty SHALL equal (level < O_WIDTH/G).
REQ-023 almost_full SHALL equal (level >= AF_LEVEL); almost_empty SHALL equal (level <= AE_LEVEL).
REQ-024 Read latency: dout and dout_valid SHALL update on the edge that accepts the read (one cycle after rd_en sampled); dout holds its last value when dout_valid=0.
REQ-025 Simultaneous accepted read and write SHALL both occur in one cycle; level += I_WIDTH/G - O_WIDTH/G; acceptance is judged on pre-update level only (no write into space freed same cycle).
REQ-026 Pointers SHALL wrap modulo L without bubbles; level SHALL never exceed L or go negative.
REQ-027 overflow SHALL pulse the cycle after wr_en with write refused; underflow the cycle after rd_en with read refused; refused requests SHALL not change state.
REQ-028 fifo_clr SHALL zero pointers, level, dout_valid, overflow, underflow next edge; a same-cycle wr_en/rd_en SHALL be ignored.

Reset
REQ-029 With rst_n=0 at an edge: pointers=0, level=0, dout=0, dout_valid=0, overflow=0, underflow=0; hence empty=1, full=0, almost_empty=1.
REQ-030 Reset mid-operation SHALL discard all stored data and take priority over fifo_clr, wr_en, rd_en.

Verification
REQ-031 Downsize I=32,O=8,MSB_FIRST=1: write 0xAABBCCDD, 4 reads -> dout 0xAA,0xBB,0xCC,0xDD, level 4->0, empty=1 after last.
REQ-032 Upsize I=8,O=32,MSB_FIRST=0: write 0x11,0x22,0x33 -> empty=1 (level 3); write 0x44 -> empty=0; read -> dout 0x44332211.
REQ-033 I=O=32,DEPTH=4: 5 writes, no reads -> full=1 after 4th, overflow pulse after 5th, level=4; 4 reads return words in order.
REQ-034 Full FIFO, simultaneous wr_en+rd_en every cycle for 8 cycles -> reads accepted, writes refused while full (overflow pulses), no corruption; sequence across pointer wrap matches reference model.
REQ-035 Read on empty -> underflow pulse next cycle, dout_valid=0, level unchanged.
REQ-036 Level 10 then fifo_clr=1 with wr_en=1 -> level=0, empty=1 next cycle; rst_n=0 mid-burst -> all REQ-029 values next edge.
